// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BHT-based branch prediction and
// the IF/ID pipeline register feeding the decode stage.
module if_stage #(
  parameter int BHT_IDX = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        changeFlow,
  input  logic [31:0] jb_addr,
  input  logic        br_resolve,
  input  logic        br_taken,
  input  logic [31:0] ex_pc_1,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_1,
  output logic        id_pred_taken,
  output logic        id_valid
);

  localparam int BHT_N = 1 << BHT_IDX;

  // Two-bit saturating counter step: up on taken, down otherwise.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        id_instr_q, id_instr_d;
  logic [31:0]        id_pc_1_q, id_pc_1_d;
  logic               id_pred_q, id_pred_d;
  logic               id_valid_q, id_valid_d;
  logic [1:0]         bht_q [BHT_N];

  logic               is_branch_s;
  logic [BHT_IDX-1:0] rd_idx_s;
  logic [BHT_IDX-1:0] wr_idx_s;
  logic [31:0]        ex_pc_s;
  logic [1:0]         rd_ctr_s;
  logic               pred_s;
  logic [31:0]        pc_plus1_s;
  logic [31:0]        br_target_s;

  // Prediction and fetch-address arithmetic; the BHT read sees the
  // registered (pre-update) counter, so a same-cycle update is not bypassed.
  always_comb begin
    is_branch_s = (imem_data[31:28] == 4'b0110);
    rd_idx_s    = pc_q[BHT_IDX-1:0];
    ex_pc_s     = ex_pc_1 - 32'd1;
    wr_idx_s    = ex_pc_s[BHT_IDX-1:0];
    rd_ctr_s    = bht_q[rd_idx_s];
    pred_s      = is_branch_s & rd_ctr_s[1];
    pc_plus1_s  = pc_q + 32'd1;
    br_target_s = pc_plus1_s + {{16{imem_data[15]}}, imem_data[15:0]};
  end

  // Next-PC priority: redirect, then stall, then predicted target, then PC+1.
  always_comb begin
    pc_d = pc_plus1_s;
    if (changeFlow) begin
      pc_d = jb_addr;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_s) begin
      pc_d = br_target_s;
    end else begin
      pc_d = pc_plus1_s;
    end
  end

  // IF/ID next state: flush on redirect (even while stalled), hold on stall.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_1_d  = id_pc_1_q;
    id_pred_d  = id_pred_q;
    id_valid_d = id_valid_q;
    if (changeFlow) begin
      id_instr_d = 32'h0000_0000;
      id_pc_1_d  = 32'h0000_0000;
      id_pred_d  = 1'b0;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_instr_d = id_instr_q;
      id_pc_1_d  = id_pc_1_q;
      id_pred_d  = id_pred_q;
      id_valid_d = id_valid_q;
    end else begin
      id_instr_d = imem_data;
      id_pc_1_d  = pc_plus1_s;
      id_pred_d  = pred_s;
      id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= 32'h0000_0000;
      id_instr_q <= 32'h0000_0000;
      id_pc_1_q  <= 32'h0000_0000;
      id_pred_q  <= 1'b0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_1_q  <= id_pc_1_d;
      id_pred_q  <= id_pred_d;
      id_valid_q <= id_valid_d;
    end
  end

  // BHT training from the EX stage; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (br_resolve) begin
      bht_q[wr_idx_s] <= sat_step(bht_q[wr_idx_s], br_taken);
    end else begin
      bht_q[wr_idx_s] <= bht_q[wr_idx_s];
    end
  end

  assign imem_addr     = pc_q;
  assign id_instr      = id_instr_q;
  assign id_pc_1       = id_pc_1_q;
  assign id_pred_taken = id_pred_q;
  assign id_valid      = id_valid_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter BHT_IDX, default 6, giving log2 of branch-history-table entries (64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port imem_addr, output, 32, word address of the instruction being fetched (equals PC).
REQ-005 SHALL have port imem_data, input, 32, instruction at imem_addr, valid combinationally in the same cycle.
REQ-006 SHALL have port stall, input, 1, hazard stall: hold PC and the IF/ID register.
REQ-007 SHALL have port changeFlow, input, 1, EX-stage redirect: jump, or branch mispredict.
REQ-008 SHALL have port jb_addr, input, 32, redirect target when changeFlow=1.
REQ-009 SHALL have port br_resolve, input, 1, EX holds a resolved conditional branch this cycle.
REQ-010 SHALL have port br_taken, input, 1, actual outcome of the resolved branch.
REQ-011 SHALL have port ex_pc_1, input, 32, pc_1 of the resolved branch; BHT index = (ex_pc_1-1)[BHT_IDX-1:0].
REQ-012 SHALL have port id_instr, output, 32, IF/ID registered instruction.
REQ-013 SHALL have port id_pc_1, output, 32, IF/ID registered PC+1.
REQ-014 SHALL have port id_pred_taken, output, 1, IF/ID registered prediction for id_instr.
REQ-015 SHALL have port id_valid, output, 1, IF/ID holds a real instruction (0 = bubble).

Function
REQ-016 SHALL treat imem_data as a conditional branch when imem_data[31:28]==4'b0110.
REQ-017 SHALL store a BHT of 2^BHT_IDX 2-bit saturating counters; predict taken when counter[1]==1.
REQ-018 SHALL read the BHT at index PC[BHT_IDX-1:0]; pred = is_branch AND counter[1].
REQ-019 SHALL select next PC by priority: changeFlow -> jb_addr; else stall -> PC; else pred -> PC+1+sext(imem_data[15:0]); else PC+1.
REQ-020 SHALL wrap all PC arithmetic modulo 2^32.
REQ-021 SHALL on changeFlow=1 load IF/ID with instr=32'h0, pc_1=0, pred=0, valid=0 (flush), regardless of stall.
REQ-022 SHALL on stall=1 and changeFlow=0 hold IF/ID unchanged.
REQ-023 SHALL otherwise load IF/ID with imem_data, PC+1, pred, valid=1; fetch-to-ID latency is one cycle.
REQ-024 SHALL on br_resolve=1 increment the indexed counter (saturate at 3) if br_taken, else decrement (saturate at 0), independent of stall and changeFlow.
REQ-025 SHALL return the pre-update counter value when the read and update indices coincide in the same cycle; the new value is visible from the next cycle.
REQ-026 SHALL leave the BHT unchanged when br_resolve=0.

Reset
REQ-027 SHALL, on a rising clk with rst_n=0, set PC=0, id_instr=0, id_pc_1=0, id_pred_taken=0, id_valid=0, and all BHT counters to 2'b01 (weakly not-taken).
REQ-028 SHALL give rst_n priority over changeFlow, stall and br_resolve; reset mid-operation discards all in-flight state.
REQ-029 SHALL drive imem_addr=0 in the first cycle after rst_n rises.

Verification
REQ-030 SHALL be verified by these scenarios: sequential fetch of non-branch words from 0 -> imem_addr 0,1,2,3; id_pc_1 1,2,3 with id_valid=1 one cycle later.
REQ-031 SHALL be verified by these scenarios: stall=1 for 2 cycles at PC=5 -> imem_addr stays 5, IF/ID unchanged; stall released -> PC 6.
REQ-032 SHALL be verified by these scenarios: changeFlow=1, jb_addr=0x40 together with stall=1 -> next imem_addr 0x40, id_valid=0, id_instr=0.
REQ-033 SHALL be verified by these scenarios: br_resolve=1, br_taken=1 twice at ex_pc_1=0x11 -> counter[0x10] goes 01->10->11; branch at PC 0x10 with imm 0x0004 -> id_pred_taken=1, next PC 0x15; a third taken update stays at 11.
REQ-034 SHALL be verified by these scenarios: branch at PC 0xFFFFFFFF with imm 0xFFFF predicted taken -> next PC 0xFFFFFFFF; PC+1 from 0xFFFFFFFF wraps to 0.
REQ-035 SHALL be verified by these scenarios: rst_n=0 asserted for one cycle mid-stream with changeFlow=1 -> PC=0, id_valid=0, all counters read 01.
